// File: rtl/pipeline_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipeline_sequencer_pkg
//  Brief   : State encodings and defaults shared by the run-control sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
package pipeline_sequencer_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd1;
    localparam logic [STATE_W-1:0] ST_STEP  = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    localparam int DRAIN_CYCLES_DEFAULT = 4;

    // Stage registers advance only in these states.
    function automatic logic is_enabled(input logic [STATE_W-1:0] state);
        return (state == ST_RUN) || (state == ST_STEP) || (state == ST_DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_sequencer_hazard_detector.sv
`default_nettype none
// ============================================================================
//  Module  : pipeline_sequencer_hazard_detector
//  Brief   : Combinational load-use compare between EX load and ID sources.
//  Revision: 1.0 - initial release
// ============================================================================
module pipeline_sequencer_hazard_detector #(
    parameter int NB_REG = 5
) (
    input  logic              mem_read,
    input  logic [NB_REG-1:0] ex_rt,
    input  logic [NB_REG-1:0] id_rs,
    input  logic [NB_REG-1:0] id_rt,
    output logic              hazard
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = mem_read
                 && (ex_rt != '0)
                 && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : pipeline_sequencer
//  Brief   : Run/step/drain FSM and hazard strobes for the 5-stage pipeline.
//  Revision: 1.0 - initial release
// ============================================================================
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int NB_REG       = 5,
    parameter int NB_CNT       = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_clear,
    input  logic              i_halt_fetched,
    input  logic              i_id_ex_mem_read,
    input  logic [NB_REG-1:0] i_id_ex_rt,
    input  logic [NB_REG-1:0] i_if_id_rs,
    input  logic [NB_REG-1:0] i_if_id_rt,
    input  logic              i_branch_taken,
    input  logic              i_jump,
    output logic              o_pipeline_enable,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic              o_if_id_flush,
    output logic              o_id_ex_bubble,
    output logic [2:0]        o_state,
    output logic              o_done,
    output logic [NB_CNT-1:0] o_cycle_count
);

    localparam int              C_DCW        = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [C_DCW-1:0] C_DRAIN_LOAD = C_DCW'(DRAIN_CYCLES - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [C_DCW-1:0]   r_drain_cnt;
    logic [NB_CNT-1:0]  r_cycle_count;

    logic w_en;
    logic w_hazard;
    logic w_stall;
    logic w_if_id_write;
    logic w_drain_start;
    logic w_clear_cnt;

    pipeline_sequencer_hazard_detector #(
        .NB_REG (NB_REG)
    ) u_hazard (
        .mem_read (i_id_ex_mem_read),
        .ex_rt    (i_id_ex_rt),
        .id_rs    (i_if_id_rs),
        .id_rt    (i_if_id_rt),
        .hazard   (w_hazard)
    );

    // HALT only counts once it actually lands in IF/ID, so a stall postpones the drain.
    assign w_drain_start = ((r_state == ST_RUN) || (r_state == ST_STEP))
                        && i_halt_fetched && w_if_id_write;
    assign w_clear_cnt   = i_clear && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_drain_start) begin
                r_drain_cnt <= C_DRAIN_LOAD;
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - C_DCW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_next_state = ST_RUN;
                end else if (i_step) begin
                    w_next_state = ST_STEP;
                end
            end
            ST_RUN: begin
                if (w_drain_start) begin
                    w_next_state = ST_DRAIN;
                end else if (!i_run) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_STEP:  w_next_state = w_drain_start ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_clear) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Stall outranks flush: a branch fed by a load resolves one cycle later.
    always_comb begin
        w_en              = is_enabled(r_state);
        w_stall           = w_en && w_hazard;
        w_if_id_write     = w_en && !w_stall;
        o_pipeline_enable = w_en;
        o_pc_write        = w_en && !w_stall && (r_state != ST_DRAIN);
        o_if_id_write     = w_if_id_write;
        o_id_ex_bubble    = w_stall;
        o_if_id_flush     = (w_en && !w_stall && (i_branch_taken || i_jump))
                         || (r_state == ST_DRAIN);
        o_state           = r_state;
        o_done            = (r_state == ST_DONE);
        o_cycle_count     = r_cycle_count;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_count <= '0;
        end else if (w_clear_cnt) begin
            r_cycle_count <= '0;
        end else if (w_en && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + NB_CNT'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipeline_sequencer
//  Brief   : Directed and randomized checks of pipeline_sequencer.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int NB_REG = 5;
    localparam int NB_CNT = 32;
    localparam int DRAIN  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b0, step = 1'b0, clear = 1'b0, halt = 1'b0;
    logic              mr = 1'b0, br = 1'b0, jmp = 1'b0;
    logic [NB_REG-1:0] ex_rt = '0, rs = '0, rt = '0;
    logic              pipeline_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, done;
    logic [2:0]        state;
    logic [NB_CNT-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 single step, 3 draining, 4 halted.
    int                m_mode = 0;
    int                m_drain_left = 0;
    logic [NB_CNT-1:0] m_count = '0;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .NB_REG       (NB_REG),
        .NB_CNT       (NB_CNT),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_run             (run),
        .i_step            (step),
        .i_clear           (clear),
        .i_halt_fetched    (halt),
        .i_id_ex_mem_read  (mr),
        .i_id_ex_rt        (ex_rt),
        .i_if_id_rs        (rs),
        .i_if_id_rt        (rt),
        .i_branch_taken    (br),
        .i_jump            (jmp),
        .o_pipeline_enable (pipeline_enable),
        .o_pc_write        (pc_write),
        .o_if_id_write     (if_id_write),
        .o_if_id_flush     (if_id_flush),
        .o_id_ex_bubble    (id_ex_bubble),
        .o_state           (state),
        .o_done            (done),
        .o_cycle_count     (cycle_count)
    );

    function automatic bit m_en();
        return (m_mode >= 1) && (m_mode <= 3);
    endfunction

    function automatic bit m_stall();
        return m_en() && mr && (ex_rt != 0) && ((ex_rt == rs) || (ex_rt == rt));
    endfunction

    // {enable, pc_write, if_id_write, flush, bubble, state[2:0], done}
    function automatic logic [8:0] m_outs();
        bit en, st, fl;
        en = m_en();
        st = m_stall();
        fl = (en && !st && (br || jmp)) || (m_mode == 3);
        return {en, en && !st && (m_mode != 3), en && !st, fl, st, 3'(m_mode), m_mode == 4};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_drain_left = 0;
        m_count = '0;
    endtask

    task automatic model_advance();
        bit fetched;
        fetched = m_en() && !m_stall();
        if (m_en() && (m_count != '1)) m_count = m_count + 1;
        case (m_mode)
            0: begin
                if (clear) m_count = '0;
                if (run) m_mode = 1;
                else if (step) m_mode = 2;
            end
            1, 2: begin
                if (halt && fetched) begin
                    m_mode = 3;
                    m_drain_left = DRAIN;
                end else if (m_mode == 2 || !run) begin
                    m_mode = 0;
                end
            end
            3: begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_mode = 4;
            end
            default: begin
                if (clear) begin
                    m_count = '0;
                    m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        run = 0; step = 0; clear = 0; halt = 0; mr = 0; br = 0; jmp = 0;
        ex_rt = '0; rs = '0; rt = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({pipeline_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, state, done} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b",
                {pipeline_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, state, done}, 9'b0);
        end
        checks++;
        if (cycle_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", cycle_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_run();
        run = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) run = 0;
            @(negedge clk);
            checks++;
            if ({pipeline_enable, pc_write} !== 2'b11) begin
                errors++;
                $display("FAIL run_enable cycle %0d: got %b expected 11", i, {pipeline_enable, pc_write});
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || cycle_count !== 10) begin
            errors++;
            $display("FAIL run_stop: got state %0d count %0d expected state 0 count 10", state, cycle_count);
        end
    endtask

    task automatic test_step();
        int enables = 0;
        clear = 1;
        tick();
        clear = 0;
        @(negedge clk);
        checks++;
        if (cycle_count !== '0) begin
            errors++;
            $display("FAIL step_clear: got %0d expected 0", cycle_count);
        end
        tick();
        for (int p = 0; p < 3; p++) begin
            step = 1;
            @(negedge clk);
            enables += int'(pipeline_enable);
            tick();
            step = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                enables += int'(pipeline_enable);
                tick();
            end
        end
        checks++;
        if (enables != 3 || cycle_count !== 3) begin
            errors++;
            $display("FAIL step_count: got enables %0d count %0d expected 3 and 3", enables, cycle_count);
        end
        // A second pulse landing while already in STEP must be dropped.
        step = 1;
        tick();
        @(negedge clk);
        tick();
        step = 0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || cycle_count !== 4) begin
            errors++;
            $display("FAIL step_drop: got state %0d count %0d expected state 0 count 4", state, cycle_count);
        end
    endtask

    task automatic test_hazard();
        clear_inputs();
        run = 1;
        tick();
        mr = 1; ex_rt = 5; rs = 5; rt = 7;
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble, pipeline_enable} !== 4'b0011) begin
            errors++;
            $display("FAIL hazard_stall: got %b expected 0011",
                {pc_write, if_id_write, id_ex_bubble, pipeline_enable});
        end
        tick();
        mr = 0;
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin
            errors++;
            $display("FAIL hazard_release: got %b expected 110", {pc_write, if_id_write, id_ex_bubble});
        end
        tick();
        mr = 1; ex_rt = 0; rs = 0; rt = 0;
        @(negedge clk);
        checks++;
        if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin
            errors++;
            $display("FAIL hazard_r0: got %b expected 110", {pc_write, if_id_write, id_ex_bubble});
        end
        tick();
        clear_inputs();
        run = 1;
    endtask

    task automatic test_branch();
        br = 1;
        @(negedge clk);
        checks++;
        if (if_id_flush !== 1'b1) begin
            errors++;
            $display("FAIL branch_flush: got %b expected 1", if_id_flush);
        end
        tick();
        br = 0;
        @(negedge clk);
        checks++;
        if (if_id_flush !== 1'b0) begin
            errors++;
            $display("FAIL branch_flush_end: got %b expected 0", if_id_flush);
        end
        tick();
        br = 1; mr = 1; ex_rt = 9; rt = 9;
        @(negedge clk);
        checks++;
        if ({if_id_flush, id_ex_bubble} !== 2'b01) begin
            errors++;
            $display("FAIL branch_stall: got %b expected 01", {if_id_flush, id_ex_bubble});
        end
        tick();
        mr = 0;
        @(negedge clk);
        checks++;
        if ({if_id_flush, id_ex_bubble} !== 2'b10) begin
            errors++;
            $display("FAIL branch_after_stall: got %b expected 10", {if_id_flush, id_ex_bubble});
        end
        tick();
        clear_inputs();
        run = 1;
    endtask

    task automatic test_halt();
        halt = 1;
        tick();
        halt = 0;
        for (int i = 0; i < DRAIN; i++) begin
            @(negedge clk);
            checks++;
            if ({state, pc_write, if_id_flush, pipeline_enable} !== {3'd3, 3'b011}) begin
                errors++;
                $display("FAIL halt_drain cycle %0d: got state %0d pcw %b flush %b en %b expected 3 0 1 1",
                    i, state, pc_write, if_id_flush, pipeline_enable);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({done, state, pipeline_enable} !== {1'b1, 3'd4, 1'b0}) begin
                errors++;
                $display("FAIL halt_done %0d: got done %b state %0d en %b expected 1 4 0",
                    i, done, state, pipeline_enable);
            end
            tick();
        end
        run = 0;
        clear = 1;
        tick();
        clear = 0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || cycle_count !== '0) begin
            errors++;
            $display("FAIL halt_clear: got state %0d count %0d expected 0 0", state, cycle_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        run = 1;
        tick();
        halt = 1;
        tick();
        halt = 0;
        tick();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({pipeline_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, state, done} !== 9'b0
            || cycle_count !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b count %0d expected all zero",
                {pipeline_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, state, done}, cycle_count);
        end
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_random();
        logic [8:0] exp;
        for (int i = 0; i < 600; i++) begin
            run   = ($urandom_range(0, 9) < 7);
            step  = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 5) == 0);
            halt  = ($urandom_range(0, 19) == 0);
            mr    = $urandom_range(0, 1);
            ex_rt = NB_REG'($urandom_range(0, 3));
            rs    = NB_REG'($urandom_range(0, 3));
            rt    = NB_REG'($urandom_range(0, 3));
            br    = ($urandom_range(0, 5) == 0);
            jmp   = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            exp = m_outs();
            checks++;
            if ({pipeline_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, state, done} !== exp) begin
                errors++;
                $display("FAIL random_outs cycle %0d: got %b expected %b", i,
                    {pipeline_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble, state, done}, exp);
            end
            checks++;
            if (cycle_count !== m_count) begin
                errors++;
                $display("FAIL random_count cycle %0d: got %0d expected %0d", i, cycle_count, m_count);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_hazard();
        test_branch();
        test_halt();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
